// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// Parametrised universal shift register. It supports hold, shift left/right,
// parallel load, rotate left/right and synchronous clear. A shift-count
// tracker pulses frame_done for one cycle when a WIDTH-th shift completes.
//
// Optional feature macro: UNIV_SHIFT_REG_ROTATE_EN
//   defined   : modes 100/101 rotate and count toward frame_done
//   undefined : no rotate logic; 100/101 behave as HOLD
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   en         in   operation enable (0 = hold everything)
//   mode       in   [2:0] operation select
//   sin_lsb    in   serial input shifted into bit 0 on SHL
//   sin_msb    in   serial input shifted into bit WIDTH-1 on SHR
//   din        in   [WIDTH-1:0] parallel load data
//   q          out  [WIDTH-1:0] register contents
//   sout_msb   out  combinational q[WIDTH-1]
//   sout_lsb   out  combinational q[0]
//   shift_cnt  out  [CW-1:0] shift/rotate ops since last load, clear or wrap
//   frame_done out  registered one-cycle pulse after the wrapping edge
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_frame_done;
    state_t           r_state;

    logic [WIDTH-1:0] w_q_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_frame_nxt;
    logic             w_is_shift;
    logic             w_is_clear;
    state_t           w_state_nxt;

    // Datapath: next register value and operation classification
    always_comb begin
        w_q_nxt    = r_q;
        w_is_shift = 1'b0;
        w_is_clear = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL: begin
                    w_q_nxt    = {r_q[WIDTH-2:0], sin_lsb};
                    w_is_shift = 1'b1;
                end
                MODE_SHR: begin
                    w_q_nxt    = {sin_msb, r_q[WIDTH-1:1]};
                    w_is_shift = 1'b1;
                end
                MODE_LOAD: begin
                    w_q_nxt    = din;
                    w_is_clear = 1'b1;
                end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
                MODE_ROL: begin
                    w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_is_shift = 1'b1;
                end
                MODE_ROR: begin
                    w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
                    w_is_shift = 1'b1;
                end
`endif
                MODE_CLR: begin
                    w_q_nxt    = '0;
                    w_is_clear = 1'b1;
                end
                // HOLD, reserved 111 and (without rotate) 100/101
                default: ;
            endcase
        end
    end

    assign w_cnt_inc = r_cnt + CW'(1);

    // Counter FSM: next state, next count and frame pulse
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_frame_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_clear) begin
                    w_cnt_nxt = '0;
                end else if (w_is_shift) begin
                    // WIDTH >= 2, so the first op of a frame never wraps
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = ST_COUNTING;
                end
            end
            ST_COUNTING: begin
                if (w_is_clear) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_is_shift) begin
                    if (w_cnt_inc == CW'(WIDTH)) begin
                        w_cnt_nxt   = '0;
                        w_frame_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q          <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
            r_state      <= ST_IDLE;
        end else begin
            r_q          <= w_q_nxt;
            r_cnt        <= w_cnt_nxt;
            r_frame_done <= w_frame_nxt;
            r_state      <= w_state_nxt;
        end
    end

    assign q          = r_q;
    assign shift_cnt  = r_cnt;
    assign frame_done = r_frame_done;
    assign sout_msb   = r_q[WIDTH-1];
    assign sout_lsb   = r_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// Directed self-checking bench for univ_shift_reg with one WIDTH=4 and one
// WIDTH=8 instance sharing clock and reset. Expected values are hand-derived.
// Rotate expectations follow UNIV_SHIFT_REG_ROTATE_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_univ_shift_reg;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;
    localparam logic [2:0] M_RSV  = 3'b111;

    logic       clk;
    logic       reset;

    logic       en4, sin_lsb4, sin_msb4;
    logic [2:0] mode4;
    logic [3:0] din4, q4;
    logic       smsb4, slsb4, fd4;
    logic [2:0] cnt4;

    logic       en8, sin_lsb8, sin_msb8;
    logic [2:0] mode8;
    logic [7:0] din8, q8;
    logic       smsb8, slsb8, fd8;
    logic [3:0] cnt8;

    int n_checks = 0;
    int n_errors = 0;

    univ_shift_reg #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .en(en4), .mode(mode4),
        .sin_lsb(sin_lsb4), .sin_msb(sin_msb4), .din(din4),
        .q(q4), .sout_msb(smsb4), .sout_lsb(slsb4),
        .shift_cnt(cnt4), .frame_done(fd4)
    );

    univ_shift_reg #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .en(en8), .mode(mode8),
        .sin_lsb(sin_lsb8), .sin_msb(sin_msb8), .din(din8),
        .q(q8), .sout_msb(smsb8), .sout_lsb(slsb8),
        .shift_cnt(cnt8), .frame_done(fd8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en4 = 1'b0; mode4 = M_HOLD; sin_lsb4 = 1'b0; sin_msb4 = 1'b0; din4 = '0;
        en8 = 1'b0; mode8 = M_HOLD; sin_lsb8 = 1'b0; sin_msb8 = 1'b0; din8 = '0;
        tick();
        tick();
        check("rst_q4",    q4,    32'h0);
        check("rst_cnt4",  cnt4,  32'h0);
        check("rst_fd4",   fd4,   32'h0);
        check("rst_smsb4", smsb4, 32'h0);
        check("rst_slsb4", slsb4, 32'h0);
        check("rst_q8",    q8,    32'h0);
        reset = 1'b0;

        // ---- Reset mid-frame (WIDTH=4) ----
        en4 = 1'b1; mode4 = M_LOAD; din4 = 4'b1010;
        tick();
        check("mf_load_q", q4, 32'hA);
        check("mf_load_cnt", cnt4, 32'h0);
        mode4 = M_SHL; sin_lsb4 = 1'b0;
        tick();
        check("mf_shl1_q", q4, 32'h4);
        check("mf_shl1_cnt", cnt4, 32'h1);
        tick();
        check("mf_shl2_q", q4, 32'h8);
        check("mf_shl2_cnt", cnt4, 32'h2);
        mode4 = M_HOLD;
        #2 reset = 1'b1;
        #1;
        check("mf_async_q", q4, 32'h0);
        check("mf_async_cnt", cnt4, 32'h0);
        check("mf_async_fd", fd4, 32'h0);
        check("mf_async_smsb", smsb4, 32'h0);
        #2 reset = 1'b0;
        tick();
        check("mf_post_fd", fd4, 32'h0);
        check("mf_post_q", q4, 32'h0);

        // ---- SIPO / SISO (WIDTH=4) ----
        mode4 = M_SHL;
        sin_lsb4 = 1'b1; tick();
        check("sipo_cnt1", cnt4, 32'h1);
        check("sipo_fd1", fd4, 32'h0);
        sin_lsb4 = 1'b0; tick();
        check("sipo_cnt2", cnt4, 32'h2);
        sin_lsb4 = 1'b1; tick();
        check("sipo_cnt3", cnt4, 32'h3);
        check("sipo_fd3", fd4, 32'h0);
        sin_lsb4 = 1'b1; tick();
        check("sipo_q", q4, 32'hB);
        check("sipo_fd4", fd4, 32'h1);
        check("sipo_cnt4", cnt4, 32'h0);
        check("sipo_slsb", slsb4, 32'h1);
        sin_lsb4 = 1'b0;
        check("siso_msb0", smsb4, 32'h1);
        tick();
        check("siso_fd_drop", fd4, 32'h0);
        check("siso_cnt1", cnt4, 32'h1);
        check("siso_msb1", smsb4, 32'h0);
        tick();
        check("siso_msb2", smsb4, 32'h1);
        tick();
        check("siso_msb3", smsb4, 32'h1);
        tick();
        check("siso_q", q4, 32'h0);
        check("siso_fd", fd4, 32'h1);

        // ---- SHR and back-to-back frames (WIDTH=4) ----
        mode4 = M_CLR;
        tick();
        check("shr_clr_q", q4, 32'h0);
        check("shr_clr_fd", fd4, 32'h0);
        mode4 = M_SHR; sin_msb4 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("shr_cnt%0d", i), cnt4, 32'((i % 4)));
            check($sformatf("shr_fd%0d", i), fd4, (i % 4 == 0) ? 32'h1 : 32'h0);
            if (i == 2) check("shr_q2", q4, 32'hC);
        end
        check("shr_q8", q4, 32'hF);
        check("shr_slsb", slsb4, 32'h1);

        // ---- Counter interruption (WIDTH=4) ----
        mode4 = M_CLR; tick();
        mode4 = M_SHL; sin_lsb4 = 1'b1;
        tick(); tick(); tick();
        check("int_cnt3", cnt4, 32'h3);
        check("int_q3", q4, 32'h7);
        mode4 = M_CLR; tick();
        check("int_clr_q", q4, 32'h0);
        check("int_clr_cnt", cnt4, 32'h0);
        check("int_clr_fd", fd4, 32'h0);
        mode4 = M_SHL; tick();
        check("int_s1_cnt", cnt4, 32'h1);
        mode4 = M_RSV; tick();
        check("int_r1_q", q4, 32'h1);
        check("int_r1_cnt", cnt4, 32'h1);
        check("int_r1_fd", fd4, 32'h0);
        mode4 = M_SHL; tick();
        mode4 = M_RSV; tick();
        check("int_r2_q", q4, 32'h3);
        check("int_r2_cnt", cnt4, 32'h2);
        mode4 = M_SHL; tick();
        check("int_s3_fd", fd4, 32'h0);
        check("int_s3_cnt", cnt4, 32'h3);
        tick();
        check("int_s4_fd", fd4, 32'h1);
        check("int_s4_cnt", cnt4, 32'h0);
        check("int_s4_q", q4, 32'hF);
        mode4 = M_HOLD; tick();
        check("int_hold_fd", fd4, 32'h0);
        check("int_hold_q", q4, 32'hF);
        en4 = 1'b0;

        // ---- Load, rotate and gating (WIDTH=8) ----
        en8 = 1'b1; mode8 = M_LOAD; din8 = 8'hA5;
        tick();
        check("rot_load_q", q8, 32'hA5);
        check("rot_load_cnt", cnt8, 32'h0);
        check("rot_load_smsb", smsb8, 32'h1);
        check("rot_load_slsb", slsb8, 32'h1);
        mode8 = M_ROL; tick();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        check("rol_q", q8, 32'h4B);
        check("rol_cnt", cnt8, 32'h1);
`else
        check("rol_q", q8, 32'hA5);
        check("rol_cnt", cnt8, 32'h0);
`endif
        mode8 = M_ROR; tick();
        check("ror_q", q8, 32'hA5);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        check("ror_cnt", cnt8, 32'h2);
`else
        check("ror_cnt", cnt8, 32'h0);
`endif
        check("ror_fd", fd8, 32'h0);
        en8 = 1'b0; mode8 = M_SHL; sin_lsb8 = 1'b1;
        tick(); tick(); tick();
        check("gate_q", q8, 32'hA5);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        check("gate_cnt", cnt8, 32'h2);
`else
        check("gate_cnt", cnt8, 32'h0);
`endif
        check("gate_fd", fd8, 32'h0);
        en8 = 1'b1; mode8 = M_SHR; sin_msb8 = 1'b0; tick();
        check("w8_shr_q", q8, 32'h52);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        check("w8_shr_cnt", cnt8, 32'h3);
`else
        check("w8_shr_cnt", cnt8, 32'h1);
`endif
        mode8 = M_LOAD; din8 = 8'h3C; tick();
        check("w8_reload_q", q8, 32'h3C);
        check("w8_reload_cnt", cnt8, 32'h0);
        check("w8_reload_smsb", smsb8, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with an enable, eight operating modes and a shift-count tracker that flags when a full word has been shifted. It replaces separate fixed 4-bit SISO, SIPO and PIPO registers with one WIDTH-bit block. It sits between serial links and parallel datapaths, serving as serialiser, deserialiser, loadable register or rotator.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), shift-counter width; derived, not overridden.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- en  input  1  operation enable; 0 means hold everything.
- mode  input  3  operation select (see Operation).
- sin_lsb  input  1  serial input entering bit 0 on a shift-left.
- sin_msb  input  1  serial input entering bit WIDTH-1 on a shift-right.
- din  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_msb  output  1  combinational, equals q[WIDTH-1].
- sout_lsb  output  1  combinational, equals q[0].
- shift_cnt  output  CW  number of shift/rotate ops since the last load, clear or wrap.
- frame_done  output  1  registered one-cycle pulse when a WIDTH-th shift completes.

## Operation
- Mode encoding and next q, applied only when en=1:
  - 000 HOLD: q unchanged.
  - 001 SHL: q <= {q[WIDTH-2:0], sin_lsb}.
  - 010 SHR: q <= {sin_msb, q[WIDTH-1:1]}.
  - 011 LOAD: q <= din.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 CLR: q <= 0 (synchronous).
  - 111: reserved, behaves as HOLD.
- Counter state machine, two states:
  - COUNTING: each SHL, SHR, ROL or ROR with en=1 increments shift_cnt. When the incremented value equals WIDTH, shift_cnt becomes 0 (wrap) and frame_done is 1 on the next cycle.
  - IDLE: shift_cnt=0 after LOAD, CLR or reset.
- LOAD and CLR zero shift_cnt and never raise frame_done.
- HOLD, reserved and en=0 leave q and shift_cnt unchanged. frame_done is 0 in any cycle where the preceding edge did not wrap the counter.
- Mixing directions (SHL then SHR) still counts every op. The counter tracks operations, not bit position.

## Timing
- Reset: q=0, shift_cnt=0, frame_done=0, and therefore sout_msb=sout_lsb=0. Takes effect immediately and asynchronously, including mid-frame; an in-progress count is discarded.
- Deassertion of reset is synchronised externally. The first op is taken on the first rising edge with reset low.
- Latency: q and shift_cnt reflect an op one edge after it is sampled. frame_done is high for exactly the cycle following the wrapping edge.
- Back-to-back frames: a shift on the same edge frame_done rises counts as 1 of the next frame. No dead cycle.
- sin_lsb, sin_msb, din and mode must be stable around the rising edge. The serial outputs change only after edges.

## Configuration
- UNIV_SHIFT_REG_ROTATE_EN.
  - Defined: modes 100/101 rotate as specified and count toward frame_done.
  - Undefined: no rotate logic is built. 100/101 behave as HOLD (q and counter unchanged, no frame_done).

## Test plan
- Reset mid-frame: WIDTH=4, load 4'b1010, SHL twice, assert reset for 3 ns between edges -> q=0000 and shift_cnt=0 immediately; frame_done stays 0.
- SIPO/SISO behaviour: WIDTH=4, en=1, mode=SHL, sin_lsb=1,0,1,1 on four edges -> q=1011 after the 4th edge. frame_done=1 for one cycle after the 4th edge, then shift_cnt=0. sout_msb sequence over the next four SHLs with sin_lsb=0 is 1,0,1,1.
- Load, rotate and gating: WIDTH=8, LOAD 8'hA5 -> q=A5 and shift_cnt=0. ROL -> 4B. ROR -> A5. en=0 with mode=SHL for 3 cycles -> q=A5 and shift_cnt=2. With macro undefined, ROL leaves q=A5 and shift_cnt=0.
- SHR and back-to-back frames: WIDTH=4, SHR with sin_msb=1 for 8 consecutive edges -> q=1111. frame_done pulses after edges 4 and 8 only; shift_cnt goes 1,2,3,0,1,2,3,0.
- Counter interruption: WIDTH=4, 3 SHL, then CLR -> q=0 and shift_cnt=0. 4 more SHL -> frame_done only after the 4th of those. Mode 111 between shifts changes nothing.
